regfile_legv8: RTL and testbench

//  Architectural register file plus NZCV status register for the LEGv8 datapath.

---
 rtl/legv8_pkg.sv | 11 +
 rtl/regfile_read_port.sv | 26 ++
 rtl/regfile_legv8.sv | 55 +++++
 tb/tb_regfile_legv8.sv | 174 +++++++++++++++++
 4 files changed

// File: rtl/legv8_pkg.sv
// Shared LEGv8 datapath constants: default widths, XZR index and NZCV bit positions.
package legv8_pkg;
  localparam int WIDTH_DEF     = 64;
  localparam int ADDR_BITS_DEF = 5;
  localparam int XZR           = 31;

  localparam int STAT_Z = 0;
  localparam int STAT_N = 1;
  localparam int STAT_C = 2;
  localparam int STAT_V = 3;
endpackage

// File: rtl/regfile_read_port.sv
// One register-file read port: XZR forcing plus write-through bypass of the pending write.
module regfile_read_port
  import legv8_pkg::*;
#(
  parameter int WIDTH     = WIDTH_DEF,
  parameter int ADDR_BITS = ADDR_BITS_DEF,
  parameter int ZERO_REG  = XZR
) (
  input  logic [ADDR_BITS-1:0] addr,
  input  logic [ADDR_BITS-1:0] waddr,
  input  logic [WIDTH-1:0]     wdata,
  input  logic                 wbyp,
  input  logic [WIDTH-1:0]     stored,
  output logic [WIDTH-1:0]     rdata
);
  localparam logic [ADDR_BITS-1:0] ZR = ADDR_BITS'(ZERO_REG);

  // XZR wins over the bypass so a discarded write to it never leaks through.
  always_comb begin
    rdata = stored;
    if (addr == ZR)
      rdata = '0;
    else if (wbyp && (addr == waddr))
      rdata = wdata;
  end
endmodule

// File: rtl/regfile_legv8.sv
// LEGv8 architectural register file (2 read, 1 write) with latched NZCV status.
module regfile_legv8
  import legv8_pkg::*;
#(
  parameter int WIDTH     = WIDTH_DEF,
  parameter int ADDR_BITS = ADDR_BITS_DEF,
  parameter int ZERO_REG  = XZR
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic [ADDR_BITS-1:0] SA,
  input  logic [ADDR_BITS-1:0] SB,
  input  logic [ADDR_BITS-1:0] DA,
  input  logic [WIDTH-1:0]     D,
  input  logic                 W,
  input  logic                 SL,
  input  logic [3:0]           status_in,
  output logic [WIDTH-1:0]     A,
  output logic [WIDTH-1:0]     B,
  output logic [3:0]           status_out
);
  localparam int NREGS = 1 << ADDR_BITS;
  localparam logic [ADDR_BITS-1:0] ZR = ADDR_BITS'(ZERO_REG);

  logic [WIDTH-1:0] regs [0:NREGS-1];
  logic             wr_en;

  // Reset both blocks the write and hides it from the read ports.
  assign wr_en = W && !reset && (DA != ZR);

  always_ff @(posedge clock) begin
    if (reset) begin
      for (int i = 0; i < NREGS; i++)
        regs[i] <= '0;
      status_out <= 4'b0;
    end else begin
      if (wr_en)
        regs[DA] <= D;
      if (SL)
        status_out <= status_in;
    end
  end

  regfile_read_port #(
    .WIDTH(WIDTH), .ADDR_BITS(ADDR_BITS), .ZERO_REG(ZERO_REG)
  ) u_port_a (
    .addr(SA), .waddr(DA), .wdata(D), .wbyp(wr_en), .stored(regs[SA]), .rdata(A)
  );

  regfile_read_port #(
    .WIDTH(WIDTH), .ADDR_BITS(ADDR_BITS), .ZERO_REG(ZERO_REG)
  ) u_port_b (
    .addr(SB), .waddr(DA), .wdata(D), .wbyp(wr_en), .stored(regs[SB]), .rdata(B)
  );
endmodule

// File: tb/tb_regfile_legv8.sv
// Directed and model-based checks of regfile_legv8 read/write, XZR, bypass, reset and status.
module tb_regfile_legv8;
  import legv8_pkg::*;

  logic        clock = 1'b0;
  logic        reset;
  logic [4:0]  SA, SB, DA;
  logic [63:0] D;
  logic        W, SL;
  logic [3:0]  status_in;
  logic [63:0] A, B;
  logic [3:0]  status_out;

  int total = 0;
  int bad   = 0;

  logic [63:0] m [0:31];
  logic [3:0]  ms;

  regfile_legv8 dut (
    .clock(clock), .reset(reset), .SA(SA), .SB(SB), .DA(DA), .D(D), .W(W), .SL(SL),
    .status_in(status_in), .A(A), .B(B), .status_out(status_out)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Advance one edge, applying the same write/status rules to the model.
  task automatic tick();
    if (!reset && W && DA != 5'd31) m[DA] = D;
    if (!reset && SL) ms = status_in;
    if (reset) begin
      for (int i = 0; i < 32; i++) m[i] = '0;
      ms = '0;
    end
    @(posedge clock);
    #1;
  endtask

  function automatic logic [63:0] exp_rd(input logic [4:0] a);
    if (a == 5'd31) return '0;
    if (!reset && W && DA == a) return D;
    return m[a];
  endfunction

  logic [63:0] ea, eb, f_prev;
  logic [64:0] sum;
  logic [3:0]  st_prev;

  initial begin
    reset = 1'b1; W = 1'b1; SL = 1'b1; DA = 5'd3; D = 64'hFF;
    SA = 5'd3; SB = 5'd3; status_in = 4'hF;
    for (int i = 0; i < 32; i++) m[i] = '0;
    ms = '0;
    @(posedge clock); #1;
    tick();
    #1;
    chk("rst_no_bypass_A", A, 64'h0);
    chk("rst_status", {60'h0, status_out}, 64'h0);
    reset = 1'b0; W = 1'b0; SL = 1'b0;
    #1;
    chk("rst_reg3", A, 64'h0);

    // write then read on both ports
    W = 1'b1; DA = 5'd5; D = 64'h0123_4567_89AB_CDEF;
    tick();
    W = 1'b0; SA = 5'd5; SB = 5'd5;
    #1;
    chk("wr_rd_A", A, 64'h0123_4567_89AB_CDEF);
    chk("wr_rd_B", B, 64'h0123_4567_89AB_CDEF);

    W = 1'b1;
    for (int i = 0; i < 31; i++) begin
      if (i == 5) continue;
      DA = 5'(i); D = 64'hA5A5_0000_0000_0000 | 64'(i * 3);
      tick();
    end

    // XZR: discarded write, no bypass
    DA = 5'd31; D = '1; SA = 5'd31;
    #1;
    chk("xzr_no_bypass", A, 64'h0);
    tick();
    W = 1'b0;
    #1;
    chk("xzr_read", A, 64'h0);
    for (int i = 0; i < 31; i++) begin
      SB = 5'(i);
      #1;
      chk($sformatf("xzr_sweep_%0d", i), B,
          (i == 5) ? 64'h0123_4567_89AB_CDEF : (64'hA5A5_0000_0000_0000 | 64'(i * 3)));
    end

    // bypass
    W = 1'b1; DA = 5'd7; D = 64'h10;
    tick();
    D = 64'h20; SA = 5'd7; SB = 5'd6;
    #1;
    chk("byp_A", A, 64'h20);
    chk("byp_B_other", B, 64'hA5A5_0000_0000_0012);
    tick();
    W = 1'b0;
    #1;
    chk("byp_after_A", A, 64'h20);
    W = 1'b1; DA = 5'd8; D = 64'hDEAD_BEEF_0000_0001; SA = 5'd8; SB = 5'd8;
    #1;
    chk("byp_both_A", A, 64'hDEAD_BEEF_0000_0001);
    chk("byp_both_B", B, 64'hDEAD_BEEF_0000_0001);
    tick();
    W = 1'b0;

    // status load and hold
    SL = 1'b1; status_in = 4'b1010;
    #1;
    chk("stat_no_bypass", {60'h0, status_out}, 64'h0);
    tick();
    chk("stat_load", {60'h0, status_out}, 64'hA);
    SL = 1'b0; status_in = 4'b0101;
    tick();
    chk("stat_hold", {60'h0, status_out}, 64'hA);

    // reset mid-sequence: stored value visible until the edge, write discarded
    reset = 1'b1; W = 1'b1; SL = 1'b1; DA = 5'd9; D = 64'h1234; SA = 5'd9; SB = 5'd7;
    #1;
    chk("midrst_A_pre", A, 64'hA5A5_0000_0000_001B);
    chk("midrst_B_pre", B, 64'h20);
    tick();
    chk("midrst_A_post", A, 64'h0);
    chk("midrst_B_post", B, 64'h0);
    chk("midrst_stat", {60'h0, status_out}, 64'h0);
    reset = 1'b0; W = 1'b0; SL = 1'b0;

    // random traffic with an adder standing in for the ALU
    f_prev = 64'h1; st_prev = 4'h0;
    for (int c = 0; c < 300; c++) begin
      SA = 5'($urandom_range(0, 31));
      SB = 5'($urandom_range(0, 31));
      DA = 5'($urandom_range(0, 31));
      W  = 1'($urandom);
      SL = 1'($urandom);
      D  = (c % 4 == 0) ? {$urandom, $urandom} : f_prev;
      status_in = st_prev;
      #1;
      ea = exp_rd(SA);
      eb = exp_rd(SB);
      chk($sformatf("rnd_A_%0d", c), A, ea);
      chk($sformatf("rnd_B_%0d", c), B, eb);
      chk($sformatf("rnd_S_%0d", c), {60'h0, status_out}, {60'h0, ms});
      sum = {1'b0, ea} + {1'b0, eb};
      f_prev = sum[63:0];
      st_prev[STAT_Z] = (sum[63:0] == 64'h0);
      st_prev[STAT_N] = sum[63];
      st_prev[STAT_C] = sum[64];
      st_prev[STAT_V] = (ea[63] == eb[63]) && (sum[63] != ea[63]);
      tick();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end
endmodule
